// File: rtl/cache_response_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : cache_response_packetizer
// Description : Queues arbiter read-returns and emits framed read-response
//               packets in order on a valid/ready router link.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_response_packetizer #(
    parameter int DATA_WIDTH    = 32,
    parameter int NET_ADDR_W    = 4,
    parameter int LOCAL_ADDRESS = 0,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 3,
    parameter int PKT_W         = 46
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  readReady,
    input  logic [NET_ADDR_W-1:0] requesterAddressIn,
    input  logic [DATA_WIDTH-1:0] cacheDataIn,
    output logic [PKT_W-1:0]      pktOut,
    output logic                  pktValid,
    input  logic                  pktReady,
    output logic [CNT_W-1:0]      fifoCount,
    output logic                  overflow,
    output logic [7:0]            dropCount
);

    localparam int                    c_PTR_W        = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      c_DEPTH        = CNT_W'(FIFO_DEPTH);
    localparam logic [NET_ADDR_W-1:0] c_SRC          = NET_ADDR_W'(LOCAL_ADDRESS);
    localparam logic [1:0]            c_TYPE_RD_RESP = 2'b10;

    logic [PKT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic [3:0]         r_seq;
    logic               r_overflow;
    logic [7:0]         r_dropCount;

    logic               w_pop;
    logic               w_accept;
    logic               w_drop;
    logic [PKT_W-1:0]   w_pkt;

    assign pktValid  = (r_count != '0);
    assign pktOut    = pktValid ? r_mem[r_rdPtr] : '0;
    assign fifoCount = r_count;
    assign overflow  = r_overflow;
    assign dropCount = r_dropCount;

    // A full queue still accepts when the head leaves at the same edge.
    assign w_pop    = pktValid && pktReady;
    assign w_accept = readReady && ((r_count < c_DEPTH) || w_pop);
    assign w_drop   = readReady && !w_accept;

    assign w_pkt = PKT_W'({c_TYPE_RD_RESP, requesterAddressIn, c_SRC, r_seq, cacheDataIn});

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wrPtr] <= w_pkt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_seq       <= '0;
            r_overflow  <= 1'b0;
            r_dropCount <= '0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
                r_seq   <= r_seq + 4'd1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropCount != 8'hFF) begin
                    r_dropCount <= r_dropCount + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_response_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_response_packetizer
// Description : Directed vector bench for cache_response_packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_response_packetizer;

    localparam int c_LOCAL = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        readReady;
    logic [3:0]  requesterAddressIn;
    logic [31:0] cacheDataIn;
    logic [45:0] pktOut;
    logic        pktValid;
    logic        pktReady;
    logic [2:0]  fifoCount;
    logic        overflow;
    logic [7:0]  dropCount;

    int total = 0;
    int bad   = 0;

    cache_response_packetizer #(
        .DATA_WIDTH   (32),
        .NET_ADDR_W   (4),
        .LOCAL_ADDRESS(c_LOCAL),
        .FIFO_DEPTH   (4),
        .CNT_W        (3),
        .PKT_W        (46)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .readReady         (readReady),
        .requesterAddressIn(requesterAddressIn),
        .cacheDataIn       (cacheDataIn),
        .pktOut            (pktOut),
        .pktValid          (pktValid),
        .pktReady          (pktReady),
        .fifoCount         (fifoCount),
        .overflow          (overflow),
        .dropCount         (dropCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rr;
        logic [3:0]  dest;
        logic [31:0] data;
        logic        pr;
        logic        expValid;
        logic [45:0] expPkt;
        logic [2:0]  expCnt;
        logic        expOv;
        logic [7:0]  expDrop;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [45:0] pk(input logic [3:0] dest, input logic [3:0] seq,
                                       input logic [31:0] data);
        logic [3:0] src;
        src = 4'(c_LOCAL);
        return {2'b10, dest, src, seq, data};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic step(input logic rr, input logic [3:0] dest, input logic [31:0] data,
                        input logic pr);
        @(negedge clk);
        readReady          = rr;
        requesterAddressIn = dest;
        cacheDataIn        = data;
        pktReady           = pr;
        @(posedge clk);
        #1;
    endtask

    task automatic chkAll(input string nm, input logic v, input logic [45:0] p,
                          input logic [2:0] c, input logic o, input logic [7:0] d);
        chk({nm, ".valid"}, 64'(pktValid), 64'(v));
        chk({nm, ".pkt"},   64'(pktOut),   64'(p));
        chk({nm, ".count"}, 64'(fifoCount), 64'(c));
        chk({nm, ".ovf"},   64'(overflow), 64'(o));
        chk({nm, ".drop"},  64'(dropCount), 64'(d));
    endtask

    initial begin
        // single push, 4-deep fill, drops, full+push+pop, drain, empty+push no bypass
        vecs[0]  = '{1'b1, 4'h5, 32'hDEADBEEF, 1'b1, 1'b1, pk(4'h5, 4'd0, 32'hDEADBEEF), 3'd1, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 46'h0,                        3'd0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 4'h1, 32'd1,        1'b0, 1'b1, pk(4'h1, 4'd1, 32'd1),        3'd1, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 4'h1, 32'd2,        1'b0, 1'b1, pk(4'h1, 4'd1, 32'd1),        3'd2, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 4'h1, 32'd3,        1'b0, 1'b1, pk(4'h1, 4'd1, 32'd1),        3'd3, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 4'h1, 32'd4,        1'b0, 1'b1, pk(4'h1, 4'd1, 32'd1),        3'd4, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 4'h1, 32'd5,        1'b0, 1'b1, pk(4'h1, 4'd1, 32'd1),        3'd4, 1'b1, 8'd1};
        vecs[7]  = '{1'b1, 4'h1, 32'd6,        1'b0, 1'b1, pk(4'h1, 4'd1, 32'd1),        3'd4, 1'b1, 8'd2};
        vecs[8]  = '{1'b1, 4'h1, 32'd7,        1'b1, 1'b1, pk(4'h1, 4'd2, 32'd2),        3'd4, 1'b1, 8'd2};
        vecs[9]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, pk(4'h1, 4'd3, 32'd3),        3'd3, 1'b1, 8'd2};
        vecs[10] = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, pk(4'h1, 4'd4, 32'd4),        3'd2, 1'b1, 8'd2};
        vecs[11] = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, pk(4'h1, 4'd5, 32'd7),        3'd1, 1'b1, 8'd2};
        vecs[12] = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 46'h0,                        3'd0, 1'b1, 8'd2};
        vecs[13] = '{1'b1, 4'h9, 32'hAA,       1'b1, 1'b1, pk(4'h9, 4'd6, 32'hAA),       3'd1, 1'b1, 8'd2};
        vecs[14] = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 46'h0,                        3'd0, 1'b1, 8'd2};

        reset              = 1'b0;
        readReady          = 1'b0;
        requesterAddressIn = '0;
        cacheDataIn        = '0;
        pktReady           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chkAll("reset", 1'b0, 46'h0, 3'd0, 1'b0, 8'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rr, vecs[i].dest, vecs[i].data, vecs[i].pr);
            chkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPkt,
                   vecs[i].expCnt, vecs[i].expOv, vecs[i].expDrop);
        end

        // Back-to-back with ready high: each packet sits one cycle at the head; seq wraps 15->0.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'(i), 32'(100 + i), 1'b1);
            chk($sformatf("b2b%0d.pkt", i), 64'(pktOut), 64'(pk(4'(i), 4'((7 + i) % 16), 32'(100 + i))));
            chk($sformatf("b2b%0d.count", i), 64'(fifoCount), 64'd1);
        end
        step(1'b0, 4'h0, 32'h0, 1'b1);
        chkAll("b2bDrain", 1'b0, 46'h0, 3'd0, 1'b1, 8'd2);

        // Fill, then keep pushing until the drop counter pins at 255.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'h7, 32'(200 + i), 1'b0);
        end
        chkAll("refill", 1'b1, pk(4'h7, 4'd11, 32'd200), 3'd4, 1'b1, 8'd2);
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 4'hE, 32'hBAD, 1'b0);
        end
        chkAll("saturate", 1'b1, pk(4'h7, 4'd11, 32'd200), 3'd4, 1'b1, 8'd255);

        // Asynchronous reset in the middle of a stall clears everything at once.
        step(1'b0, 4'h0, 32'h0, 1'b1);
        chk("preRst.count", 64'(fifoCount), 64'd3);
        @(negedge clk);
        pktReady = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chkAll("midRst", 1'b0, 46'h0, 3'd0, 1'b0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 4'h2, 32'h55, 1'b0);
        chkAll("postRst", 1'b1, pk(4'h2, 4'd0, 32'h55), 3'd1, 1'b0, 8'd0);
        step(1'b0, 4'h0, 32'h0, 1'b1);
        chk("postRstDrain.count", 64'(fifoCount), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
